// File: rtl/multichannel_average_filter.sv
// multichannel_average_filter
// Per-channel boxcar mean over a run-time selectable power-of-two window
// (N = 2^k, k = clamped win_log2). Results are rounded half toward +inf and are
// only emitted once the window holds N samples. Changing k flushes all state.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   win_log2   window exponent, values above log2(MAX_WINDOW) clamp
//   in_valid   sample qualifier shared by all channels
//   in_data    packed signed samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  one-cycle strobe per accepted sample once the window is full
//   out_data   packed rounded means, same packing as in_data
//   warm       high while the window is full
module multichannel_average_filter #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned MAX_WINDOW = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [$clog2($clog2(MAX_WINDOW)+1)-1:0]    win_log2,
  input  logic                                       in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]               in_data,
  output logic                                       out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]               out_data,
  output logic                                       warm
);

  localparam int unsigned LOG2_MAX = $clog2(MAX_WINDOW);
  localparam int unsigned KW       = $clog2(LOG2_MAX + 1);
  localparam int unsigned AW       = DATA_WIDTH + LOG2_MAX + 1;
  localparam int unsigned FW       = LOG2_MAX + 1;

  logic [KW-1:0]                 k_c;
  logic [KW-1:0]                 k_q;
  logic                          flush_c;
  logic                          accept_c;
  logic [FW-1:0]                 n_win_c;
  logic [FW-1:0]                 fill_cnt;
  logic [FW-1:0]                 fill_nxt_c;
  logic                          full_c;
  logic [LOG2_MAX-1:0]           wr_ptr;
  logic [LOG2_MAX-1:0]           rd_ptr_c;
  logic                          pend;
  logic signed [AW-1:0]          rnd_c;
  logic [NUM_CH*DATA_WIDTH-1:0]  mean_c;

  // Window selection, flush detection and shared fill bookkeeping
  always_comb begin
    k_c = win_log2;
    if (win_log2 > KW'(LOG2_MAX)) begin
      k_c = KW'(LOG2_MAX);
    end
    flush_c    = (k_c != k_q);
    accept_c   = in_valid && !flush_c;
    n_win_c    = FW'(1) << k_q;
    full_c     = (fill_cnt == n_win_c);
    fill_nxt_c = full_c ? fill_cnt : fill_cnt + FW'(1);
    // For N = MAX_WINDOW the low bits of N are zero, so the leaving slot is
    // the one about to be overwritten; the async read returns its old value.
    rd_ptr_c   = wr_ptr - n_win_c[LOG2_MAX-1:0];
  end

  // Rounding offset 2^(k-1), zero for k = 0
  always_comb begin
    rnd_c = '0;
    if (k_q != '0) begin
      rnd_c = $signed(AW'(1) << (k_q - KW'(1)));
    end
  end

  // Per-channel history, accumulator and rounded mean
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] mem [MAX_WINDOW];
    logic signed [DATA_WIDTH-1:0] smp_c;
    logic signed [DATA_WIDTH-1:0] leave_c;
    logic signed [AW-1:0]         acc;
    logic signed [AW-1:0]         acc_nxt_c;

    assign smp_c     = $signed(in_data[c*DATA_WIDTH +: DATA_WIDTH]);
    assign leave_c   = full_c ? mem[rd_ptr_c] : '0;
    assign acc_nxt_c = acc + AW'(smp_c) - AW'(leave_c);
    assign mean_c[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((acc + rnd_c) >>> k_q);

    // History storage carries no reset; stale entries are never read
    // because leaving is gated by full_c.
    always_ff @(posedge clk) begin
      if (accept_c) begin
        mem[wr_ptr] <= smp_c;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n || flush_c) begin
        acc <= '0;
      end else if (accept_c) begin
        acc <= acc_nxt_c;
      end
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= k_c;
      fill_cnt  <= '0;
      wr_ptr    <= '0;
      warm      <= 1'b0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      k_q <= k_c;
      if (flush_c) begin
        fill_cnt  <= '0;
        wr_ptr    <= '0;
        warm      <= 1'b0;
        pend      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= pend;
        if (pend) begin
          out_data <= mean_c;
        end
        // pend marks that acc now holds a full-window sum for this sample
        pend <= accept_c && (fill_nxt_c == n_win_c);
        if (accept_c) begin
          fill_cnt <= fill_nxt_c;
          wr_ptr   <= wr_ptr + LOG2_MAX'(1);
          warm     <= (fill_nxt_c == n_win_c);
        end
      end
    end
  end

endmodule

// File: tb/tb_multichannel_average_filter.sv
// Testbench for multichannel_average_filter: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// queue-based model of the windowed mean.
module tb_multichannel_average_filter;

  localparam int DW = 12;
  localparam int NC = 2;
  localparam int LM = 5;
  localparam int KW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [KW-1:0]     win_log2;
  logic              in_valid;
  logic [NC*DW-1:0]  in_data;
  logic              out_valid;
  logic [NC*DW-1:0]  out_data;
  logic              warm;

  always #5 clk = ~clk;

  multichannel_average_filter #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC),
    .MAX_WINDOW (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .win_log2  (win_log2),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .warm      (warm)
  );

  int checks = 0;
  int errors = 0;

  // Model state: samples accepted since last reset/flush, current window,
  // the output owed next cycle, and the expected visible outputs.
  int q0[$];
  int q1[$];
  int kq;
  bit pend;
  int pend_d[2];
  bit e_valid;
  int e_data[2];
  bit e_warm;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rmean(input int qq[$], input int k);
    int s = 0;
    foreach (qq[i]) s += qq[i];
    if (k == 0) return s;
    return (s + (1 << (k - 1))) >>> k;
  endfunction

  task automatic model_edge(input bit r, input int win, input bit v, input int d0, input int d1);
    int kc;
    kc = (win > LM) ? LM : win;
    if (!r) begin
      kq = kc; q0.delete(); q1.delete();
      pend = 0; e_valid = 0; e_data[0] = 0; e_data[1] = 0;
    end else if (kc != kq) begin
      kq = kc; q0.delete(); q1.delete();
      pend = 0; e_valid = 0;
    end else begin
      e_valid = pend;
      if (pend) begin
        e_data[0] = pend_d[0];
        e_data[1] = pend_d[1];
      end
      pend = 0;
      if (v) begin
        q0.push_back(d0);
        q1.push_back(d1);
        if (q0.size() > (1 << kq)) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
        if (q0.size() == (1 << kq)) begin
          pend = 1;
          pend_d[0] = rmean(q0, kq);
          pend_d[1] = rmean(q1, kq);
        end
      end
    end
    e_warm = (q0.size() == (1 << kq));
  endtask

  // Drive one cycle of inputs, advance the model, then compare away from the edge
  task automatic step(input bit r, input int win, input bit v, input int d0, input int d1);
    rst_n    = r;
    win_log2 = KW'(win);
    in_valid = v;
    in_data  = {DW'(d1), DW'(d0)};
    model_edge(r, win, v, d0, d1);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(e_valid));
    chk("warm", int'(warm), int'(e_warm));
    chk("out_data_ch0", int'($signed(out_data[DW-1:0])), e_data[0]);
    chk("out_data_ch1", int'($signed(out_data[2*DW-1:DW])), e_data[1]);
  endtask

  function automatic int ch0();
    return int'($signed(out_data[DW-1:0]));
  endfunction

  function automatic int ch1();
    return int'($signed(out_data[2*DW-1:DW]));
  endfunction

  initial begin
    rst_n = 1'b0; win_log2 = '0; in_valid = 1'b0; in_data = '0;

    // Reset with active input; then k=2 step of 100 / -100
    step(0, 2, 1, 2047, 2047);
    step(0, 2, 1, 2047, 2047);
    chk("lit_rst_valid", int'(out_valid), 0);
    chk("lit_rst_data", int'(out_data), 0);
    chk("lit_rst_warm", int'(warm), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 2, 1, 100, -100);
      if (i == 3) chk("lit_step_not_yet", int'(out_valid), 0);
      if (i == 4) begin
        chk("lit_step_first_valid", int'(out_valid), 1);
        chk("lit_step_ch0", ch0(), 100);
        chk("lit_step_ch1", ch1(), -100);
      end
    end
    chk("lit_step_hold_ch0", ch0(), 100);

    // Rounding with k=1 and pass-through with k=0
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 2, 0);
    step(1, 1, 0, 0, 0);
    chk("lit_round_pos", ch0(), 2);
    step(1, 1, 1, -1, 0);
    step(1, 1, 1, -2, 0);
    step(1, 1, 0, 0, 0);
    chk("lit_round_neg", ch0(), -1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, -2048, 7);
    step(1, 0, 0, 0, 0);
    chk("lit_k0_min", ch0(), -2048);
    chk("lit_k0_ch1", ch1(), 7);

    // Full-depth extremes across several pointer wraps; win_log2=7 clamps to 5
    step(0, 5, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(1, 5, 1, 2047, -2048);
    step(1, 5, 0, 0, 0);
    chk("lit_full_max", ch0(), 2047);
    chk("lit_full_min_ch1", ch1(), -2048);
    for (int i = 0; i < 64; i++) step(1, 7, 1, -2048, 2047);
    step(1, 7, 0, 0, 0);
    chk("lit_full_final", ch0(), -2048);
    chk("lit_clamp_warm", int'(warm), 1);

    // Gapped valid with ramp, k=3
    step(0, 3, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 3, 1, i, -i);
      step(1, 3, 0, 0, 0);
      if (i == 7) chk("lit_gap_mean7", ch0(), 4);
      if (i == 15) chk("lit_gap_mean15", ch0(), 12);
    end

    // Window change while warm drops the coinciding sample and pending output
    step(0, 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 3, 1, 500, 500);
    step(1, 1, 1, 999, 999);
    chk("lit_flush_valid", int'(out_valid), 0);
    chk("lit_flush_warm", int'(warm), 0);
    step(1, 1, 1, 50, -50);
    step(1, 1, 1, 70, -70);
    step(1, 1, 0, 0, 0);
    chk("lit_flush_mean", ch0(), 60);
    chk("lit_flush_mean_ch1", ch1(), -60);

    // Randomized traffic with occasional window changes and resets
    begin
      int win;
      win = 2;
      for (int n = 0; n < 3000; n++) begin
        bit r;
        bit v;
        if ($urandom_range(0, 59) == 0) win = $urandom_range(0, 7);
        r = ($urandom_range(0, 399) != 0);
        v = ($urandom_range(0, 9) < 7);
        step(r, win, v, $signed(DW'($urandom)), $signed(DW'($urandom)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multichannel_average_filter.md
# multichannel_average_filter

Runtime-configurable, multi-channel boxcar averager; the next generation of the team's fixed-window smoothing filter. Averages each of NUM_CH signed channels over a power-of-two window selected at run time (1 to MAX_WINDOW samples), advances only on qualified samples, and rounds rather than truncates. Sits between the sample-rate front end (ADC or audio capture) and downstream scaling/display logic. Outputs are withheld until the window is full, so downstream logic never sees partial-window averages.

## Interface
- DATA_WIDTH, 12: signed sample width per channel.
- NUM_CH, 2: number of independent channels sharing one valid strobe.
- MAX_WINDOW, 32: largest window, power of two ≥ 2; LOG2_MAX = $clog2(MAX_WINDOW).
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- win_log2  in  $clog2(LOG2_MAX+1)  window exponent k; N = 2^k. Values > LOG2_MAX clamp to LOG2_MAX.
- in_valid  in  1  sample qualifier; all channels accepted together.
- in_data  in  NUM_CH*DATA_WIDTH  channel c in bits [c*DATA_WIDTH +: DATA_WIDTH], signed.
- out_valid  out  1  one-cycle pulse per accepted sample once window is full.
- out_data  out  NUM_CH*DATA_WIDTH  rounded per-channel mean, same packing as in_data.
- warm  out  1  high while the window is full; low during fill.

## Operation
- Per-channel history: circular buffer of MAX_WINDOW entries, one shared write pointer wr_ptr (LOG2_MAX bits, wraps). History RAM has no reset.
- On accepted sample (in_valid=1, no flush this cycle), per channel: leaving = buf[(wr_ptr - N) mod MAX_WINDOW] if fill_cnt ≥ N, else 0; acc <= acc + in - leaving; buf[wr_ptr] <= in; wr_ptr++; fill_cnt saturates at N.
- Read of the leaving entry precedes the write in the same cycle (N = MAX_WINDOW reads the slot being overwritten; old value required).
- acc: signed, DATA_WIDTH+LOG2_MAX+1 bits; no overflow possible.
- Output: k=0 → out = acc; k>0 → out = (acc + 2^(k-1)) >>> k (round half toward +inf, arithmetic shift). Result always within DATA_WIDTH signed range; no saturation logic.
- warm = (fill_cnt == N).
- Window change: win_log2 (after clamp) registered each cycle as k_q. When clamped win_log2 ≠ k_q: flush — acc, fill_cnt, wr_ptr, warm, pending output valid all cleared on that edge; in_valid in that cycle discarded; k_q takes new value.
- No flow control: block accepts a sample every cycle; out_valid has no ready.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, warm=0, acc=0, fill_cnt=0, wr_ptr=0, k_q=clamped win_log2. Reset mid-fill or mid-stream discards all state and any in-flight output.
- Latency 2: sample accepted at edge E updates acc at E; out_data/out_valid registered at E+1; out_valid high for the cycle after E+1.
- First out_valid: for the N-th accepted sample after reset/flush (k=0: first sample).
- Back-to-back in_valid: one out_valid per cycle, no bubbles. Gaps in in_valid produce identical gaps in out_valid.
- out_data holds its last value when out_valid=0.
- Flush at E+1 suppresses the output due from a sample accepted at E.
- warm updates with fill_cnt (same edge as acc).

## Test plan
- Reset/defaults: hold rst_n=0 two cycles with in_valid=1, in_data=0x7FF → out_valid=0, out_data=0, warm=0 throughout; release, k=2 → first out_valid after 4th sample.
- Step, k=2, NUM_CH=2: ch0 feed 100 continuously, ch1 feed −100 → first output ch0=100, ch1=−100, two cycles after 4th accept; remains constant.
- Rounding, k=1: ch0 samples 1,2 → 2 (1.5 rounds up); samples −1,−2 → −1; k=0 with 0x800 → passes −2048 unchanged.
- Full-depth extremes, k=5: 32 samples of 2047 then 32 of −2048 → outputs 2047, then ramp, final −2048; no wrap artefacts at wr_ptr rollover over ≥3 wraps.
- Gapped valid: in_valid toggling 1,0,1,0 with k=3, ramp 0..15 → out_valid pattern matches input gaps; output after sample 7 = 4 (mean 3.5 rounded), after sample 15 = 12.
- Window change mid-stream: warm at k=3, switch win_log2 to 1 in same cycle as in_valid → that sample dropped, warm=0, pending out_valid suppressed; next out_valid after 2 new samples with their mean; win_log2=7 with MAX_WINDOW=32 behaves as k=5.
